// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: streaming running max/min (with first-occurrence indices) over IEEE-754 single-precision bursts
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        element handshake; in_data = element, in_last = final element of burst
//   out_valid/out_ready      result handshake, one record per burst
//   out_max/out_min          extreme elements under sign-magnitude total ordering
//   out_max_idx/out_min_idx  0-based index of first occurrence of each extreme
//   out_count                elements in burst modulo 2^IDX_W
//   out_ovf                  burst held more than 2^IDX_W elements
//   out_nan_seen             at least one NaN was accepted
// Build option: FP_NAN_SKIP_EN excludes NaNs from max/min selection.
module fp_minmax_reduce #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [31:0]      out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_nan_seen
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           state_q, state_d;
    logic [31:0]      max_q, max_d, min_q, min_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d, count_q, count_d, idx;
    logic             ovf_q, ovf_d, nan_q, nan_d;
    logic             acc, first, is_nan, take_max, take_min;
`ifdef FP_NAN_SKIP_EN
    logic             have_q, have_d;
`endif
    // Bit-exact with the FP compare block: +0 > -0, NaNs ranked by raw magnitude.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        return (a == b) ? 1'b0 : (a[31] != b[31]) ? ~a[31] :
               a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    endfunction
    assign in_ready     = (state_q != DONE);
    assign out_valid    = (state_q == DONE);
    assign out_max      = out_valid ? max_q : '0;
    assign out_min      = out_valid ? min_q : '0;
    assign out_max_idx  = out_valid ? max_idx_q : '0;
    assign out_min_idx  = out_valid ? min_idx_q : '0;
    assign out_count    = out_valid ? count_q : '0;
    assign out_ovf      = out_valid & ovf_q;
    assign out_nan_seen = out_valid & nan_q;
    assign acc    = in_valid & in_ready;
    assign first  = (state_q == IDLE);
    assign is_nan = (&in_data[30:23]) & (|in_data[22:0]);
    assign idx    = first ? '0 : count_q;
`ifdef FP_NAN_SKIP_EN
    // The first non-NaN element seeds max/min even if earlier NaNs were seen.
    assign take_max = ~is_nan & (first | ~have_q | gt(in_data, max_q));
    assign take_min = ~is_nan & (first | ~have_q | gt(min_q, in_data));
`else
    assign take_max = first | gt(in_data, max_q);
    assign take_min = first | gt(min_q, in_data);
`endif
    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        nan_d     = nan_q;
`ifdef FP_NAN_SKIP_EN
        have_d    = have_q;
`endif
        if (acc) begin
            if (take_max) begin
                max_d     = in_data;
                max_idx_d = idx;
            end
            if (take_min) begin
                min_d     = in_data;
                min_idx_d = idx;
            end
`ifdef FP_NAN_SKIP_EN
            // All-NaN default; replaced by the first non-NaN element.
            if (first & is_nan) begin
                max_d     = 32'h7FC0_0000;
                min_d     = 32'h7FC0_0000;
                max_idx_d = '0;
                min_idx_d = '0;
            end
            have_d = ~is_nan | (~first & have_q);
`endif
            count_d = idx + 1'b1;
            // count_q == 0 in ACCUM means 2^IDX_W elements are already held.
            ovf_d   = ~first & (ovf_q | (count_q == '0));
            nan_d   = is_nan | (~first & nan_q);
            state_d = in_last ? DONE : ACCUM;
        end
        if (out_valid & out_ready) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            nan_q     <= 1'b0;
`ifdef FP_NAN_SKIP_EN
            have_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            nan_q     <= nan_d;
`ifdef FP_NAN_SKIP_EN
            have_q    <= have_d;
`endif
        end
    end
endmodule

// File: tb/tb_fp_minmax_reduce.sv
// tb_fp_minmax_reduce: directed and random bursts checked against an ordered-key reference model
module tb_fp_minmax_reduce;
    localparam int IDX_W = 2;
    localparam int CAP   = 1 << IDX_W;
    logic             clk = 1'b0, rst = 1'b1;
    logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready, out_valid, out_ovf, out_nan_seen;
    logic [31:0]      out_max, out_min;
    logic [IDX_W-1:0] out_max_idx, out_min_idx, out_count;
    int compared = 0, mismatched = 0;

    fp_minmax_reduce #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_min(out_min), .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
        .out_count(out_count), .out_ovf(out_ovf), .out_nan_seen(out_nan_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Maps a float onto a signed integer whose natural order is the required total order (-0 just below +0).
    function automatic longint key(input logic [31:0] v);
        return v[31] ? -longint'({1'b0, v[30:0]}) - 1 : longint'({1'b0, v[30:0]});
    endfunction

    function automatic bit nan(input logic [31:0] v);
        return v[30:23] == 8'hFF && v[22:0] != 0;
    endfunction

    task automatic check_out(input logic [31:0] q[$], input string tag);
        logic [31:0] mx = 32'h7FC0_0000, mn = 32'h7FC0_0000;
        int mxi = 0, mni = 0;
        bit have = 0, ns = 0;
        foreach (q[i]) begin
            if (nan(q[i])) ns = 1;
`ifdef FP_NAN_SKIP_EN
            if (nan(q[i])) continue;
`endif
            if (!have || key(q[i]) > key(mx)) begin mx = q[i]; mxi = i; end
            if (!have || key(q[i]) < key(mn)) begin mn = q[i]; mni = i; end
            have = 1;
        end
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".max"}, out_max, mx);
        chk({tag, ".min"}, out_min, mn);
        chk({tag, ".max_idx"}, out_max_idx, mxi % CAP);
        chk({tag, ".min_idx"}, out_min_idx, mni % CAP);
        chk({tag, ".count"}, out_count, q.size() % CAP);
        chk({tag, ".ovf"}, out_ovf, q.size() > CAP);
        chk({tag, ".nan_seen"}, out_nan_seen, ns);
    endtask

    // Streams q back to back, holds the result for 'hold' cycles, then completes the handshake.
    task automatic send_burst(input logic [31:0] q[$], input int hold, input string tag);
        foreach (q[i]) begin
            chk({tag, ".accept_ready"}, in_ready, 1);
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = (i == q.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check_out(q, tag);
            @(posedge clk); #1;
        end
        check_out(q, tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".valid_cleared"}, out_valid, 0);
        chk({tag, ".ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] pool[8] = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0001, 32'hFFC0_0000, 32'h3F80_0000, 32'hBF80_0000};
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.valid", out_valid, 0);
        chk("reset.max", out_max, 0);
        chk("reset.min", out_min, 0);
        chk("reset.count", out_count, 0);
        chk("reset.flags", {out_ovf, out_nan_seen}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        send_burst('{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000}, 0, "basic");
        chk("basic.max_literal", out_max, 0);
        send_burst('{32'h0000_0000, 32'h8000_0000, 32'h0000_0000}, 0, "zeros");
        send_burst('{32'h4120_0000}, 5, "backpressure");
        send_burst('{32'h7FC0_0001, 32'h3F80_0000}, 0, "nan");
        send_burst('{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'hC000_0000}, 0, "ovf");
        send_burst('{32'hFFC0_0000, 32'h7FC0_0001}, 1, "all_nan");
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset.valid", out_valid, 0);
        chk("midreset.in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("midreset.valid_later", out_valid, 0);
        send_burst('{32'hBF80_0000}, 0, "after_reset");
        for (int b = 0; b < 60; b++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, CAP + 3)); i++)
                q.push_back($urandom_range(0, 2) == 0 ? $urandom : pool[$urandom_range(0, 7)]);
            send_burst(q, int'($urandom_range(0, 3)), $sformatf("rand%0d", b));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
